// File: rtl/bram_cfg_pkg.sv
// Shared definitions for the configurable simple-dual-port BRAM: mode encodings,
// address-to-row/lane decode and lane-width helpers.
package bram_cfg_pkg;

    typedef enum logic [1:0] {
        MODE_W1 = 2'b00,
        MODE_W2 = 2'b01,
        MODE_W4 = 2'b10
    } mode_e;

    localparam int NUM_LANES = 4;

    // The reserved encoding 2'b11 behaves exactly like full width.
    function automatic mode_e norm_mode(input logic [1:0] m);
        case (m)
            2'b01:   return MODE_W2;
            2'b10:   return MODE_W4;
            default: return MODE_W1;
        endcase
    endfunction

    function automatic int lane_width(input int max_width, input mode_e m);
        case (m)
            MODE_W2: return max_width / 2;
            MODE_W4: return max_width / 4;
            default: return max_width;
        endcase
    endfunction

    // Callers truncate the result to the physical row width.
    function automatic logic [31:0] addr_row(input logic [31:0] addr, input mode_e m);
        case (m)
            MODE_W2: return addr >> 1;
            MODE_W4: return addr >> 2;
            default: return addr;
        endcase
    endfunction

    function automatic logic [1:0] addr_lane(input logic [1:0] addr_lo, input mode_e m);
        case (m)
            MODE_W2: return {1'b0, addr_lo[0]};
            MODE_W4: return addr_lo;
            default: return 2'b00;
        endcase
    endfunction

    // Quarter-granular write enables for one logical lane.
    function automatic logic [3:0] lane_we(input logic [1:0] lane, input mode_e m);
        case (m)
            MODE_W2: return lane[0] ? 4'b1100 : 4'b0011;
            MODE_W4: return 4'b0001 << lane;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/bram_sdp_array.sv
// Raw DEPTH x WIDTH storage with per-quarter write enables and a registered
// read port; reads return the pre-write contents on a same-row collision.
module bram_sdp_array
    import bram_cfg_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 512
) (
    input  logic                       clk,
    input  logic [NUM_LANES-1:0]       wr_we,
    input  logic [$clog2(DEPTH)-1:0]   wr_row,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_row,
    output logic [WIDTH-1:0]           rd_data
);

    localparam int LANE_W = WIDTH / NUM_LANES;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_we[i]) begin
                mem_q[wr_row][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
            end
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_row];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/bram_sdp_cfg.sv
// Simple-dual-port BRAM with runtime aspect ratio (x1, x2, x4 depth), optional
// output register, read-valid pipeline and selectable read-during-write result.
module bram_sdp_cfg
    import bram_cfg_pkg::*;
#(
    parameter int MAX_WIDTH = 40,
    parameter int MIN_DEPTH = 512,
    parameter int OUT_REG   = 1,
    parameter int RDW_NEW   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   mode,
    input  logic                         wr_en,
    input  logic [$clog2(MIN_DEPTH)+1:0] wr_addr,
    input  logic [MAX_WIDTH-1:0]         wr_data,
    input  logic                         rd_en,
    input  logic [$clog2(MIN_DEPTH)+1:0] rd_addr,
    output logic [MAX_WIDTH-1:0]         rd_data,
    output logic                         rd_valid,
    output logic                         mode_busy
);

    localparam int AW     = $clog2(MIN_DEPTH);
    localparam int HALF_W = lane_width(MAX_WIDTH, MODE_W2);
    localparam int QUAR_W = lane_width(MAX_WIDTH, MODE_W4);

    mode_e                mode_n;
    logic                 wr_go;
    logic [AW-1:0]        wr_row, rd_row;
    logic [1:0]           wr_lane, rd_lane;
    logic [3:0]           arr_we;
    logic [MAX_WIDTH-1:0] arr_wdata, arr_rdata, wr_narrow, lane_data;
    logic                 kill;

    mode_e                mode_q, mode_d;
    logic                 mode_busy_q, mode_busy_d;
    logic                 s1_valid_q, s1_valid_d;
    mode_e                s1_mode_q, s1_mode_d;
    logic [1:0]           s1_lane_q, s1_lane_d;
    logic                 s1_fwd_q, s1_fwd_d;
    logic [MAX_WIDTH-1:0] s1_wdata_q, s1_wdata_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [MAX_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [MAX_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin : decode
        mode_n    = norm_mode(mode);
        wr_go     = wr_en & ~reset;
        wr_row    = AW'(addr_row(32'(wr_addr), mode_n));
        wr_lane   = addr_lane(wr_addr[1:0], mode_n);
        rd_row    = AW'(addr_row(32'(rd_addr), mode_n));
        rd_lane   = addr_lane(rd_addr[1:0], mode_n);
        arr_we    = wr_go ? lane_we(wr_lane, mode_n) : 4'b0000;
        arr_wdata = wr_data;
        wr_narrow = wr_data;
        // Narrow data is replicated so every lane position sees it; arr_we picks one.
        case (mode_n)
            MODE_W2: begin
                arr_wdata = {2{wr_data[HALF_W-1:0]}};
                wr_narrow = MAX_WIDTH'(wr_data[HALF_W-1:0]);
            end
            MODE_W4: begin
                arr_wdata = {4{wr_data[QUAR_W-1:0]}};
                wr_narrow = MAX_WIDTH'(wr_data[QUAR_W-1:0]);
            end
            default: ;
        endcase
    end

    bram_sdp_array #(
        .WIDTH (MAX_WIDTH),
        .DEPTH (MIN_DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_we   (arr_we),
        .wr_row  (wr_row),
        .wr_data (arr_wdata),
        .rd_en   (rd_en),
        .rd_row  (rd_row),
        .rd_data (arr_rdata)
    );

    // Read handshake: rd_en has no backpressure; each accepted read yields exactly
    // one rd_valid pulse 1 (OUT_REG=0) or 2 (OUT_REG=1) edges later, unless a mode
    // change kills it, in which case it produces no pulse and rd_data is held.
    always_comb begin : pipe
        mode_d      = mode_n;
        mode_busy_d = (mode_n != mode_q);
        kill        = (mode_n != mode_q) | mode_busy_q;
        s1_valid_d  = rd_en & ~kill;
        s1_mode_d   = mode_n;
        s1_lane_d   = rd_lane;
        s1_fwd_d    = (RDW_NEW != 0) && wr_go && rd_en &&
                      (wr_row == rd_row) && (wr_lane == rd_lane);
        s1_wdata_d  = wr_narrow;

        lane_data = arr_rdata;
        if (s1_fwd_q) begin
            lane_data = s1_wdata_q;
        end else begin
            case (s1_mode_q)
                MODE_W2: lane_data = MAX_WIDTH'(s1_lane_q[0] ? arr_rdata[MAX_WIDTH-1:HALF_W]
                                                             : arr_rdata[HALF_W-1:0]);
                MODE_W4: lane_data = MAX_WIDTH'(arr_rdata[s1_lane_q*QUAR_W +: QUAR_W]);
                default: ;
            endcase
        end

        s2_valid_d = s1_valid_q & ~kill;
        s2_data_d  = s1_valid_q ? lane_data : s2_data_q;
        if (OUT_REG != 0) begin
            rd_valid_d = s2_valid_q & ~kill;
            rd_data_d  = rd_valid_d ? s2_data_q : rd_data_q;
        end else begin
            rd_valid_d = s1_valid_q & ~kill;
            rd_data_d  = rd_valid_d ? lane_data : rd_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= mode_n;
            mode_busy_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            mode_q      <= mode_d;
            mode_busy_q <= mode_busy_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Payload-only stages: qualified by the valids above, so no reset needed.
    always_ff @(posedge clk) begin
        s1_mode_q  <= s1_mode_d;
        s1_lane_q  <= s1_lane_d;
        s1_fwd_q   <= s1_fwd_d;
        s1_wdata_q <= s1_wdata_d;
        s2_data_q  <= s2_data_d;
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign mode_busy = mode_busy_q;

endmodule

// File: tb/tb_bram_sdp_cfg.sv
// Directed bench: two instances (OUT_REG=1/RDW_NEW=0 and OUT_REG=0/RDW_NEW=1)
// share stimulus; each output is checked at its own read latency.
module tb_bram_sdp_cfg;

    logic        clk;
    logic        reset;
    logic [1:0]  mode;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [39:0] wr_data;
    logic        rd_en;
    logic [10:0] rd_addr;

    logic [39:0] a_rd_data, b_rd_data;
    logic        a_rd_valid, b_rd_valid;
    logic        a_busy, b_busy;

    int checks   = 0;
    int failures = 0;
    logic [1:0] cur_mode;

    typedef struct {
        logic [1:0]  mode;
        logic        wr;
        logic [10:0] wa;
        logic [39:0] wd;
        logic        rd;
        logic [10:0] ra;
        logic [39:0] exp_a;
        logic [39:0] exp_b;
    } vec_t;

    vec_t vecs[$];

    bram_sdp_cfg #(.MAX_WIDTH(40), .MIN_DEPTH(512), .OUT_REG(1), .RDW_NEW(0)) dut_a (
        .clk(clk), .reset(reset), .mode(mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .mode_busy(a_busy)
    );

    bram_sdp_cfg #(.MAX_WIDTH(40), .MIN_DEPTH(512), .OUT_REG(0), .RDW_NEW(1)) dut_b (
        .clk(clk), .reset(reset), .mode(mode),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .mode_busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [1:0] nm(input logic [1:0] m);
        return (m == 2'b11) ? 2'b00 : m;
    endfunction

    function automatic vec_t mk(input logic [1:0] m, input logic w, input logic [10:0] wa,
                                input logic [39:0] wd, input logic r, input logic [10:0] ra,
                                input logic [39:0] ea, input logic [39:0] eb);
        vec_t v;
        v.mode = m; v.wr = w; v.wa = wa; v.wd = wd;
        v.rd = r; v.ra = ra; v.exp_a = ea; v.exp_b = eb;
        return v;
    endfunction

    task automatic apply_vec(input int idx, input vec_t v);
        if (nm(v.mode) != nm(cur_mode)) begin
            mode = v.mode;
            tick();
            check($sformatf("v%0d a_busy_set", idx), 40'(a_busy), 40'd1);
            check($sformatf("v%0d b_busy_set", idx), 40'(b_busy), 40'd1);
            tick();
            check($sformatf("v%0d a_busy_clr", idx), 40'(a_busy), 40'd0);
        end else if (v.mode != cur_mode) begin
            mode = v.mode;
            tick();
            check($sformatf("v%0d a_busy_alias", idx), 40'(a_busy), 40'd0);
        end
        cur_mode = v.mode;
        wr_en = v.wr; wr_addr = v.wa; wr_data = v.wd;
        rd_en = v.rd; rd_addr = v.ra;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        check($sformatf("v%0d b_valid", idx), 40'(b_rd_valid), 40'(v.rd));
        check($sformatf("v%0d a_valid_early", idx), 40'(a_rd_valid), 40'd0);
        if (v.rd) check($sformatf("v%0d b_data", idx), b_rd_data, v.exp_b);
        tick();
        check($sformatf("v%0d a_valid", idx), 40'(a_rd_valid), 40'(v.rd));
        check($sformatf("v%0d b_valid_late", idx), 40'(b_rd_valid), 40'd0);
        if (v.rd) check($sformatf("v%0d a_data", idx), a_rd_data, v.exp_a);
    endtask

    initial begin
        // Vector table: {mode, wr, wa, wd, rd, ra, exp_a (old on collision), exp_b (new)}
        vecs.push_back(mk(2'd0, 1, 11'd5,     40'hAB_CDEF_0123, 0, 11'd0,     40'h0, 40'h0));
        vecs.push_back(mk(2'd0, 0, 11'd0,     40'h0,            1, 11'd5,     40'hAB_CDEF_0123, 40'hAB_CDEF_0123));
        vecs.push_back(mk(2'd1, 1, 11'd10,    40'h12345,        0, 11'd0,     40'h0, 40'h0));
        vecs.push_back(mk(2'd1, 1, 11'd11,    40'h6789A,        0, 11'd0,     40'h0, 40'h0));
        vecs.push_back(mk(2'd0, 0, 11'd0,     40'h0,            1, 11'd5,     40'h67_89A1_2345, 40'h67_89A1_2345));
        vecs.push_back(mk(2'd3, 0, 11'd0,     40'h0,            1, 11'h605,   40'h67_89A1_2345, 40'h67_89A1_2345));
        vecs.push_back(mk(2'd0, 1, 11'd3,     40'hFF_FFFF_FFFF, 0, 11'd0,     40'h0, 40'h0));
        vecs.push_back(mk(2'd2, 1, 11'd13,    40'hFF_FFFF_FC00, 0, 11'd0,     40'h0, 40'h0));
        vecs.push_back(mk(2'd2, 0, 11'd0,     40'h0,            1, 11'd12,    40'h3FF, 40'h3FF));
        vecs.push_back(mk(2'd2, 0, 11'd0,     40'h0,            1, 11'd13,    40'h000, 40'h000));
        vecs.push_back(mk(2'd2, 0, 11'd0,     40'h0,            1, 11'd14,    40'h3FF, 40'h3FF));
        vecs.push_back(mk(2'd2, 1, 11'd7,     40'h111,          0, 11'd0,     40'h0, 40'h0));
        vecs.push_back(mk(2'd2, 1, 11'd7,     40'hFF_FFFF_F222, 1, 11'd7,     40'h111, 40'h222));
        vecs.push_back(mk(2'd2, 0, 11'd0,     40'h0,            1, 11'd7,     40'h222, 40'h222));
        vecs.push_back(mk(2'd2, 1, 11'd6,     40'h155,          1, 11'd7,     40'h222, 40'h222));
        vecs.push_back(mk(2'd2, 0, 11'd0,     40'h0,            1, 11'd6,     40'h155, 40'h155));
        vecs.push_back(mk(2'd0, 0, 11'd0,     40'h0,            1, 11'd3,     40'hFF_FFF0_03FF, 40'hFF_FFF0_03FF));
        vecs.push_back(mk(2'd0, 1, 11'd8,     40'h11_1111_1111, 0, 11'd0,     40'h0, 40'h0));
        vecs.push_back(mk(2'd0, 1, 11'd8,     40'h22_2222_2222, 1, 11'h208,   40'h11_1111_1111, 40'h22_2222_2222));
        vecs.push_back(mk(2'd0, 0, 11'd0,     40'h0,            1, 11'd8,     40'h22_2222_2222, 40'h22_2222_2222));
        vecs.push_back(mk(2'd1, 0, 11'd0,     40'h0,            1, 11'd11,    40'h6789A, 40'h6789A));
        vecs.push_back(mk(2'd1, 0, 11'd0,     40'h0,            1, 11'h40B,   40'h6789A, 40'h6789A));

        // Clock/reset: reset with a non-default mode, which must load without a busy cycle.
        reset = 1'b1; mode = 2'd2; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        repeat (3) tick();
        check("reset a_valid", 40'(a_rd_valid), 40'd0);
        check("reset a_data", a_rd_data, 40'd0);
        check("reset b_valid", 40'(b_rd_valid), 40'd0);
        check("reset b_data", b_rd_data, 40'd0);
        reset = 1'b0;
        tick();
        check("post reset a_busy", 40'(a_busy), 40'd0);
        check("post reset b_busy", 40'(b_busy), 40'd0);
        cur_mode = 2'd2;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(i, vecs[i]);
        end

        // Mode change on the edge after a read, then a read issued during the busy cycle.
        rd_en = 1'b1; rd_addr = 11'd10;
        tick();
        rd_en = 1'b0; mode = 2'd0;
        tick();
        check("mchg a_busy", 40'(a_busy), 40'd1);
        check("mchg b_busy", 40'(b_busy), 40'd1);
        check("mchg b_valid_killed", 40'(b_rd_valid), 40'd0);
        rd_en = 1'b1; rd_addr = 11'd5;
        tick();
        rd_en = 1'b0;
        check("mchg a_valid_killed", 40'(a_rd_valid), 40'd0);
        check("mchg a_busy_clr", 40'(a_busy), 40'd0);
        tick();
        check("mchg b_busy_read_killed", 40'(b_rd_valid), 40'd0);
        tick();
        check("mchg a_busy_read_killed", 40'(a_rd_valid), 40'd0);
        cur_mode = 2'd0;
        apply_vec(100, mk(2'd0, 0, 11'd0, 40'h0, 1, 11'd5, 40'h67_89A1_2345, 40'h67_89A1_2345));

        // Reset with two reads in flight and a write that must be ignored.
        rd_en = 1'b1; rd_addr = 11'd5;
        tick();
        rd_addr = 11'd3;
        tick();
        check("rst b_valid_before", 40'(b_rd_valid), 40'd1);
        check("rst b_data_before", b_rd_data, 40'h67_89A1_2345);
        check("rst a_valid_before", 40'(a_rd_valid), 40'd0);
        rd_en = 1'b0; reset = 1'b1;
        wr_en = 1'b1; wr_addr = 11'd5; wr_data = 40'h0;
        tick();
        reset = 1'b0; wr_en = 1'b0;
        check("rst a_valid", 40'(a_rd_valid), 40'd0);
        check("rst a_data", a_rd_data, 40'd0);
        check("rst b_valid", 40'(b_rd_valid), 40'd0);
        check("rst b_data", b_rd_data, 40'd0);
        check("rst a_busy", 40'(a_busy), 40'd0);
        tick();
        check("rst a_valid_drained", 40'(a_rd_valid), 40'd0);
        check("rst a_data_held", a_rd_data, 40'd0);
        check("rst b_valid_drained", 40'(b_rd_valid), 40'd0);
        apply_vec(101, mk(2'd0, 0, 11'd0, 40'h0, 1, 11'd5, 40'h67_89A1_2345, 40'h67_89A1_2345));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_sdp_cfg.md
Name: bram_sdp_cfg

Overview:
- Parametrised simple-dual-port block RAM: one write port and one independent read port on a shared clock.
- Runtime-selectable aspect ratio over one physical array: MIN_DEPTH x MAX_WIDTH, 2*MIN_DEPTH x MAX_WIDTH/2, or 4*MIN_DEPTH x MAX_WIDTH/4.
- Adds over the fixed single-port RAM primitives:
  - separate read and write addresses in the same cycle;
  - an optional output register;
  - a read-valid pipeline;
  - defined read-during-write behaviour.
- Target for the next-generation BRAM techmap cells.

Parameters:
- MAX_WIDTH, 40, widest data width; must be divisible by 4.
- MIN_DEPTH, 512, rows of the physical array; must be a power of 2.
- OUT_REG, 1, 1 = registered output (2-cycle read latency); 0 = 1-cycle read latency.
- RDW_NEW, 0, 0 = read returns old data on an address collision; 1 = read returns newly written data.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- mode  input  2  00 = MIN_DEPTH x MAX_WIDTH; 01 = 2x depth, 1/2 width; 10 = 4x depth, 1/4 width; 11 = reserved, treated as 00.
- wr_en  input  1  write strobe.
- wr_addr  input  log2(MIN_DEPTH)+2  write address.
- wr_data  input  MAX_WIDTH  write data; narrow modes use the LSBs only.
- rd_en  input  1  read strobe.
- rd_addr  input  log2(MIN_DEPTH)+2  read address.
- rd_data  output  MAX_WIDTH  read data; narrow modes return the slice in the LSBs, upper bits zero.
- rd_valid  output  1  rd_data holds the result of an accepted read.
- mode_busy  output  1  high for the cycle after a mode change; reads are discarded during it.

Behaviour:
- Physical storage is MIN_DEPTH rows x MAX_WIDTH bits. AW = log2(MIN_DEPTH).
- Address split per mode:
  - mode 00: row = addr[AW-1:0]; upper bits ignored.
  - mode 01: row = addr[AW:1]; lane = addr[0] selects the 20-bit half (lane 0 = bits [19:0]).
  - mode 10: row = addr[AW+1:2]; lane = addr[1:0] selects the 10-bit quarter (lane 0 = bits [9:0]).
  - Address bits above the mode's range are ignored. There is no error signal.
- Write:
  - On the clk edge with wr_en = 1, only the selected lane of the row is written.
  - Other lanes of that row are preserved.
  - Write occurs regardless of rd_en.
- Read:
  - rd_en = 1 at edge N captures the row and lane.
  - OUT_REG = 0: rd_data and rd_valid update at edge N+1.
  - OUT_REG = 1: rd_data and rd_valid update at edge N+2.
  - rd_valid is a pure pipeline of rd_en. It is high for exactly one cycle per accepted read, with back-to-back reads allowed.
- rd_data holds its last value when no read completes.
- Collision: wr_en and rd_en in the same cycle, same row, same lane.
  - RDW_NEW = 0: the read returns the pre-write lane.
  - RDW_NEW = 1: the read returns wr_data's lane.
  - Same row but different lane: the read returns the stored lane unaffected. Behaviour is identical in both settings.
- Mode change:
  - mode is registered internally as mode_q.
  - When mode differs from mode_q at an edge, mode_busy = 1 for the following cycle.
  - Every read in flight or issued during that cycle completes with rd_valid = 0.
  - Writes during the mode_busy cycle still occur, using the new mode.
- Reset (synchronous, at any cycle, including with reads in flight):
  - rd_data = 0, rd_valid = 0, all pipeline valids = 0, mode_busy = 0.
  - mode_q loads the current mode with no busy cycle.
  - Memory contents are not reset.
  - A write with wr_en = 1 in the reset cycle is ignored.
- Uninitialised memory reads return X in simulation. The bench must write before reading.

Decomposition:
- Package bram_cfg_pkg holds:
  - mode encodings MODE_W1, MODE_W2, MODE_W4;
  - the function computing row and lane from address and mode;
  - lane-width constants derived from MAX_WIDTH.
- Sub-module bram_sdp_array:
  - raw MIN_DEPTH x MAX_WIDTH array with per-lane write enables (4 lanes) and a synchronous read port;
  - no reset;
  - maps onto the vendor spram/dpram primitive.
- The top level owns:
  - address decode;
  - lane write-enable generation;
  - collision forwarding;
  - read lane select and zero-extension;
  - output register, valid pipeline and mode tracking.

Test Plan:
- Mode 00, OUT_REG = 1:
  - Stimulus: write addr 5 = 0xAB_CDEF_0123, then rd_en addr 5 at edge N.
  - Required: rd_valid = 1 and rd_data = 0xABCDEF0123 at edge N+2; rd_valid low at N+1 and N+3.
- Mode 01 lane packing:
  - Stimulus: write addr 10 = 0x12345, then addr 11 = 0x6789A. Switch to mode 00 and wait out mode_busy. Read addr 5.
  - Required: rd_data = 0x6789A_12345.
- Mode 10 partial write:
  - Stimulus: fill row 3 in mode 00 with 0xFF_FFFF_FFFF. Switch to mode 10 and write addr 13 = 0x000. Read addr 12, then 13.
  - Required: 0x3FF then 0x000; the upper 30 bits of rd_data are zero.
- Collision, RDW_NEW = 0 and RDW_NEW = 1:
  - Stimulus: addr 7 holds 0x111. In the same cycle, write addr 7 = 0x222 and read addr 7.
  - Required: returns 0x111 (RDW_NEW = 0) or 0x222 (RDW_NEW = 1); a following read returns 0x222 in both.
- Mode change mid-read:
  - Stimulus: rd_en issued, then mode changes on the next edge.
  - Required: mode_busy = 1 for one cycle, the affected reads complete with rd_valid = 0, and a subsequent read is valid.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle with 2 reads in flight.
  - Required: rd_valid = 0 and rd_data = 0 the cycle after reset; previously written memory is still readable after reset.
